mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_pick2.sv | 26 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the two-port memory arbiter:
//   - arb_state_t : arbiter FSM state encoding
//   - PORT_F/D    : requester identifiers (fetch = 0, data = 1)
//   - CNT_W       : width of the memory-wait counter (covers TIMEOUT up to 255)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin choice.
//   Ports:
//     req        in   2  request vector, bit index = port id (PORT_F/PORT_D)
//     last_grant in   1  port id granted most recently
//     grant_any  out  1  at least one request present
//     grant_port out  1  port id to grant (meaningful when grant_any = 1)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_any,
    output logic       grant_port
);

    always_comb begin
        grant_any  = |req;
        grant_port = PORT_F;
        // Data wins when it is alone, or on contention when fetch went last.
        if (req[PORT_D] && (!req[PORT_F] || (last_grant == PORT_F))) begin
            grant_port = PORT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a read-only fetch port and a read/write data port onto a
//   single memory port. One transaction is in flight at a time; each is
//   answered with a one-cycle ready pulse, with err set when the memory
//   did not answer within TIMEOUT wait cycles.
//   Ports:
//     i_clk, i_reset                    clock, synchronous active-high reset
//     f_valid, f_addr, f_ready          fetch requester (port 0)
//     d_valid, d_we, d_addr, d_wdata,
//     d_ready                           data requester (port 1)
//     rdata, err                        shared response, valid with a ready
//     mem_valid, mem_we, mem_addr,
//     mem_wdata                         memory request (registered, latched)
//     mem_ready, mem_rdata              memory completion and read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,

    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,

    output logic [DATA_W-1:0] rdata,
    output logic              err,

    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter value in the final wait cycle; no mem_ready there means abort.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    logic             last_grant;
    logic             cur_port;
    logic [CNT_W-1:0] wait_cnt;

    logic             grant_any;
    logic             grant_port;

    rr_pick2 u_pick (
        .req        ({d_valid, f_valid}),
        .last_grant (last_grant),
        .grant_any  (grant_any),
        .grant_port (grant_port)
    );

    always_ff @(posedge i_clk) begin
        // Ready/err are single-cycle pulses; they only rise on BUSY exit.
        f_ready <= 1'b0;
        d_ready <= 1'b0;
        err     <= 1'b0;

        if (i_reset) begin
            state      <= ST_IDLE;
            last_grant <= PORT_F;
            cur_port   <= PORT_F;
            wait_cnt   <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state      <= ST_BUSY;
                        cur_port   <= grant_port;
                        last_grant <= grant_port;
                        wait_cnt   <= '0;
                        mem_valid  <= 1'b1;
                        if (grant_port == PORT_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= f_addr;
                            mem_wdata <= '0;
                        end
                    end
                end

                ST_BUSY: begin
                    // mem_ready takes priority over the abort in the last wait cycle.
                    if (mem_ready) begin
                        rdata     <= mem_rdata;
                        mem_valid <= 1'b0;
                        f_ready   <= (cur_port == PORT_F);
                        d_ready   <= (cur_port == PORT_D);
                        state     <= ST_RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        rdata     <= '0;
                        err       <= 1'b1;
                        mem_valid <= 1'b0;
                        f_ready   <= (cur_port == PORT_F);
                        d_ready   <= (cur_port == PORT_D);
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiter instances (TIMEOUT = 4 and 8) share the requester inputs;
//   each has its own memory responder. A transaction-level model predicts,
//   per instance, the grant order, the memory-request window, the ready
//   cycle and the response contents from the arbitration and timing rules.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          f_valid = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          d_valid = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    logic          f_ready   [2];
    logic          d_ready   [2];
    logic          err       [2];
    logic [DW-1:0] rdata     [2];
    logic          mem_valid [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic          mem_ready [2] = '{1'b0, 1'b0};
    logic [DW-1:0] mem_rdata [2] = '{'0, '0};

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut0 (
        .i_clk(clk), .i_reset(i_reset),
        .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready[0]),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready[0]), .rdata(rdata[0]), .err(err[0]),
        .mem_valid(mem_valid[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut1 (
        .i_clk(clk), .i_reset(i_reset),
        .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready[1]),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready[1]), .rdata(rdata[1]), .err(err[1]),
        .mem_valid(mem_valid[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int unsigned   to_k     [2] = '{4, 8};
    bit            armed        = 1'b0;
    bit            inflight [2] = '{1'b0, 1'b0};
    bit            last_d   [2] = '{1'b0, 1'b0};
    int unsigned   ne       [2] = '{0, 0};   // first posedge a new grant may happen
    int unsigned   g_at     [2] = '{0, 0};   // grant posedge
    int unsigned   r_at     [2] = '{0, 0};   // posedge after which ready is visible
    int unsigned   dly      [2] = '{0, 0};   // responder delay after mem_valid rises
    bit            g_d      [2] = '{1'b0, 1'b0};
    logic [AW-1:0] e_addr   [2] = '{'0, '0};
    logic [DW-1:0] e_wd     [2] = '{'0, '0};
    logic [DW-1:0] e_rd     [2] = '{'0, '0};
    bit            e_we     [2] = '{1'b0, 1'b0};
    bit            e_err    [2] = '{1'b0, 1'b0};

    int            force_dly    = -1;
    bit            force_rd_en  = 1'b0;
    logic [DW-1:0] force_rd     = '0;
    int unsigned   cyc          = 0;
    int            order_q[$];

    // Drive the responder and decide the grant for the coming posedge p.
    task automatic prep_k(input int k, input int unsigned p);
        logic          mr;
        logic [DW-1:0] mrd;
        bit            take_d;
        mr  = 1'b0;
        mrd = $urandom;
        if (i_reset) begin
            mr          = ($urandom_range(0, 1) == 0);
            inflight[k] = 1'b0;
            last_d[k]   = 1'b0;
            ne[k]       = p + 1;
        end else begin
            if (inflight[k] && dly[k] < to_k[k] && p == g_at[k] + 1 + dly[k]) begin
                mr = 1'b1;
                if (force_rd_en) mrd = force_rd;
                e_rd[k] = mrd;
            end else if (!(inflight[k] && p >= g_at[k] + 1 && p <= r_at[k])) begin
                // Outside the memory-wait window mem_ready must be ignored.
                mr = ($urandom_range(0, 3) == 0);
            end
            if (!inflight[k] && p >= ne[k] && (f_valid || d_valid)) begin
                take_d      = d_valid && (!f_valid || !last_d[k]);
                last_d[k]   = take_d;
                g_d[k]      = take_d;
                inflight[k] = 1'b1;
                g_at[k]     = p;
                e_addr[k]   = take_d ? d_addr : f_addr;
                e_we[k]     = take_d ? d_we : 1'b0;
                e_wd[k]     = take_d ? d_wdata : '0;
                dly[k]      = (force_dly >= 0) ? int'(force_dly) : $urandom_range(0, to_k[k] + 1);
                e_err[k]    = (dly[k] >= to_k[k]);
                r_at[k]     = e_err[k] ? p + to_k[k] : p + 1 + dly[k];
                if (e_err[k]) e_rd[k] = '0;
            end
        end
        mem_ready[k] = mr;
        mem_rdata[k] = mrd;
    endtask

    // Compare DUT outputs visible after posedge p.
    task automatic check_k(input int k, input int unsigned p);
        string pre;
        bit    ev, fr, dr;
        pre = $sformatf("i%0d/c%0d", k, p);
        if (k == 0) begin
            if (f_ready[0] === 1'b1) order_q.push_back(0);
            if (d_ready[0] === 1'b1) order_q.push_back(1);
        end
        if (!armed) return;
        if (i_reset) begin
            chk({pre, " rst mem_valid"}, 64'(mem_valid[k]), 64'd0);
            chk({pre, " rst f_ready"},   64'(f_ready[k]),   64'd0);
            chk({pre, " rst d_ready"},   64'(d_ready[k]),   64'd0);
            chk({pre, " rst err"},       64'(err[k]),       64'd0);
            chk({pre, " rst rdata"},     64'(rdata[k]),     64'd0);
            chk({pre, " rst mem_addr"},  64'(mem_addr[k]),  64'd0);
            chk({pre, " rst mem_we"},    64'(mem_we[k]),    64'd0);
            chk({pre, " rst mem_wdata"}, 64'(mem_wdata[k]), 64'd0);
            return;
        end
        ev = inflight[k] && p >= g_at[k] && p < r_at[k];
        fr = inflight[k] && p == r_at[k] && !g_d[k];
        dr = inflight[k] && p == r_at[k] && g_d[k];
        chk({pre, " mem_valid"}, 64'(mem_valid[k]), 64'(ev));
        if (ev) begin
            chk({pre, " mem_addr"},  64'(mem_addr[k]),  64'(e_addr[k]));
            chk({pre, " mem_we"},    64'(mem_we[k]),    64'(e_we[k]));
            chk({pre, " mem_wdata"}, 64'(mem_wdata[k]), 64'(e_wd[k]));
        end
        chk({pre, " f_ready"}, 64'(f_ready[k]), 64'(fr));
        chk({pre, " d_ready"}, 64'(d_ready[k]), 64'(dr));
        chk({pre, " err"},     64'(err[k]),     64'((fr || dr) && e_err[k]));
        if (fr || dr) chk({pre, " rdata"}, 64'(rdata[k]), 64'(e_rd[k]));
        if (inflight[k] && p == r_at[k]) begin
            inflight[k] = 1'b0;
            ne[k]       = p + 2;
        end
    endtask

    // Called at a negedge with inputs set for the next posedge.
    task automatic tick();
        int unsigned p;
        p = cyc + 1;
        for (int k = 0; k < 2; k++) prep_k(k, p);
        @(posedge clk);
        cyc = p;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_k(k, p);
        if (i_reset) armed = 1'b1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int unsigned n);
        i_reset = 1'b1;
        ticks(n);
        i_reset = 1'b0;
    endtask

    task automatic rand_inputs();
        if (f_valid) begin
            if ($urandom_range(0, 4) == 0) f_valid = 1'b0;
        end else if ($urandom_range(0, 2) == 0) f_valid = 1'b1;
        if (d_valid) begin
            if ($urandom_range(0, 4) == 0) d_valid = 1'b0;
        end else if ($urandom_range(0, 2) == 0) d_valid = 1'b1;
        if ($urandom_range(0, 1) == 0) f_addr = $urandom;
        if ($urandom_range(0, 1) == 0) begin
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom_range(0, 1));
        end
        i_reset = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);

        // Single fetch, zero memory delay, known read data.
        force_dly   = 0;
        force_rd_en = 1'b1;
        force_rd    = 32'hDEADBEEF;
        f_valid = 1'b1;
        f_addr  = 32'h100;
        tick();
        f_valid = 1'b0;
        f_addr  = 32'h999;
        ticks(5);

        // Contention held from reset: expected order D, F, D, F.
        force_rd_en = 1'b0;
        force_dly   = 1;
        do_reset(1);
        order_q.delete();
        f_valid = 1'b1;
        d_valid = 1'b1;
        d_we    = 1'b0;
        ticks(24);
        f_valid = 1'b0;
        d_valid = 1'b0;
        ticks(4);
        chk("order count", 64'(order_q.size() >= 4), 64'd1);
        if (order_q.size() >= 4) begin
            chk("order 0", 64'(order_q[0]), 64'd1);
            chk("order 1", 64'(order_q[1]), 64'd0);
            chk("order 2", 64'(order_q[2]), 64'd1);
            chk("order 3", 64'(order_q[3]), 64'd0);
        end

        // Write with 5-cycle memory delay; inputs change after the grant.
        force_dly = 5;
        d_valid = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h12345678;
        tick();
        d_valid = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'hFFFF_0000;
        d_wdata = 32'h0BAD_F00D;
        ticks(12);

        // Memory never answers: both instances abort at their own limit.
        force_dly = 1000;
        d_valid = 1'b1;
        d_addr  = 32'h80;
        tick();
        d_valid = 1'b0;
        ticks(14);

        // Answer in the last allowed wait cycle of each instance.
        force_dly = 3;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        ticks(14);
        force_dly = 7;
        f_valid = 1'b1;
        f_addr  = 32'h2000;
        tick();
        f_valid = 1'b0;
        ticks(14);

        // Reset while waiting on memory, then a normal request.
        force_dly = 1000;
        d_valid = 1'b1;
        d_addr  = 32'h300;
        tick();
        d_valid = 1'b0;
        ticks(2);
        do_reset(1);
        ticks(3);
        force_dly = 1;
        f_valid = 1'b1;
        f_addr  = 32'h440;
        tick();
        f_valid = 1'b0;
        ticks(6);

        // Randomized traffic, delays, spurious mem_ready and resets.
        force_dly = -1;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end
        i_reset = 1'b0;
        f_valid = 1'b0;
        d_valid = 1'b0;
        ticks(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
